bat_microsequencer: RTL

- Parametrised microcoded control sequencer for the BatAmateur CPU.
- Fetches, decodes and executes 16-bit instructions by driving per-cycle strobes to the PC, MAR, RAM, IR, register file and ALU.
- Generalises the fixed 8-register controller in three ways: register count is parametric, RAM accesses use a ready handshake with timeout, and the block adds HALT/RUN control and an illegal-operand flag.

---
 rtl/bat_microsequencer.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bat_microsequencer.sv
// Microcoded fetch/decode/execute sequencer for the BatAmateur CPU.
// All strobes are registered on the falling clock edge from the current state.
module bat_microsequencer #(
  parameter int NUM_REGS = 8,
  parameter int ALU_OP_W = 5,
  parameter int FLAG_W   = 8,
  parameter int ZERO_BIT = 0,
  parameter int WAIT_MAX = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [15:0]         INSTR,
  input  logic [FLAG_W-1:0]   ALU_REG,
  input  logic                RAM_READY,
  input  logic                RUN,
  output logic                PC_INC,
  output logic                PC_RW,
  output logic                PC_EN,
  output logic                MAR_LOAD,
  output logic                MAR_EN,
  output logic                RAM_RW,
  output logic                RAM_EN,
  output logic                IR_LOAD,
  output logic                IR_EN,
  output logic [NUM_REGS-1:0] REGS_INC,
  output logic [NUM_REGS-1:0] REGS_RW,
  output logic [NUM_REGS-1:0] REGS_EN,
  output logic                ALU_EN,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                HALTED,
  output logic                ILLEGAL,
  output logic                BUS_ERR
);

  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [NUM_REGS-1:0] A_HOT = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] B_HOT = NUM_REGS'(2);

  typedef enum logic [2:0] {
    ST_F0 = 3'd0,
    ST_F1 = 3'd1,
    ST_E0 = 3'd2,
    ST_E1 = 3'd3,
    ST_E2 = 3'd4,
    ST_H  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                pc_inc_q, pc_inc_d, pc_rw_q, pc_rw_d, pc_en_q, pc_en_d;
  logic                mar_load_q, mar_load_d, mar_en_q, mar_en_d;
  logic                ram_rw_q, ram_rw_d, ram_en_q, ram_en_d;
  logic                ir_load_q, ir_load_d, ir_en_q, ir_en_d;
  logic [NUM_REGS-1:0] regs_inc_q, regs_inc_d, regs_rw_q, regs_rw_d, regs_en_q, regs_en_d;
  logic                alu_en_q, alu_en_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                halted_q, halted_d, illegal_q, illegal_d;

  logic [3:0]          op;
  logic [4:0]          aluop;
  logic                dsel;
  logic [2:0]          r1, r2;
  logic [1:0]          cond;
  logic                is_regop, is_mov, is_inc, zflag, jump_taken, jump_halt;
  logic [NUM_REGS-1:0] r1_hot, r2_hot, xfer_hot, dst_hot;
  logic                operands_ok, ram_access, do_xfer;
  logic                flags_unused;

  assign op       = INSTR[15:12];
  assign aluop    = INSTR[11:7];
  assign dsel     = INSTR[6];
  assign r1       = INSTR[5:3];
  assign r2       = INSTR[2:0];
  assign cond     = INSTR[13:12];
  assign is_regop = (op == 4'b0111);
  assign is_mov   = (aluop == 5'b11111);
  assign is_inc   = (aluop == 5'b11110);
  assign zflag    = ALU_REG[ZERO_BIT];
  assign flags_unused = ^ALU_REG;

  // One-hot operand selects; an operand past the last register decodes to all zeros.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hot
    assign r1_hot[gi] = (r1 == 3'(gi));
    assign r2_hot[gi] = (r2 == 3'(gi));
  end

  assign operands_ok = (|r1_hot) & (|r2_hot);
  assign xfer_hot    = INSTR[12] ? B_HOT : A_HOT;
  assign dst_hot     = dsel ? A_HOT : B_HOT;
  assign jump_halt   = (cond == 2'b11);

  always_comb begin
    case (cond)
      2'b00:   jump_taken = 1'b1;
      2'b01:   jump_taken = zflag;
      2'b10:   jump_taken = ~zflag;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    bus_err_d  = bus_err_q;
    pc_inc_d   = 1'b0;
    pc_rw_d    = 1'b1;
    pc_en_d    = 1'b0;
    mar_load_d = 1'b0;
    mar_en_d   = 1'b1;
    ram_rw_d   = 1'b1;
    ram_en_d   = 1'b0;
    ir_load_d  = 1'b1;
    ir_en_d    = 1'b0;
    regs_inc_d = '0;
    regs_rw_d  = '1;
    regs_en_d  = '0;
    alu_en_d   = 1'b0;
    alu_op_d   = '0;
    illegal_d  = 1'b0;
    ram_access = 1'b0;
    do_xfer    = 1'b0;

    case (state_q)
      ST_F0: begin
        pc_en_d    = 1'b1;
        mar_load_d = 1'b1;
        state_d    = ST_F1;
      end
      ST_F1: begin
        ram_en_d   = 1'b1;
        ir_en_d    = 1'b1;
        ram_access = 1'b1;
        pc_inc_d   = RAM_READY;
        state_d    = ST_E0;
      end
      ST_E0: begin
        if (is_regop) begin
          state_d = ST_F0;
          if (!operands_ok) begin
            illegal_d = 1'b1;
          end else if (is_mov) begin
            regs_en_d = r1_hot | r2_hot;
            regs_rw_d = ~r1_hot | r2_hot;
          end else if (is_inc) begin
            regs_inc_d = r1_hot;
          end else begin
            state_d = ST_E1;
            if (r1 != 3'd0) begin
              regs_en_d = A_HOT | r1_hot;
              regs_rw_d = ~A_HOT;
            end
          end
        end else if (op[3:2] == 2'b01) begin
          state_d = jump_halt ? ST_H : ST_F0;
          if (jump_taken) begin
            ir_en_d   = 1'b1;
            ir_load_d = 1'b0;
            pc_en_d   = 1'b1;
            pc_rw_d   = 1'b0;
          end
        end else begin
          ir_en_d    = 1'b1;
          ir_load_d  = 1'b0;
          mar_load_d = 1'b1;
          state_d    = ST_E1;
        end
      end
      ST_E1: begin
        if (is_regop) begin
          state_d = ST_E2;
          if (r2 != 3'd1) begin
            regs_en_d = B_HOT | r2_hot;
            regs_rw_d = ~B_HOT;
          end
        end else begin
          case (op[3:2])
            2'b11: begin
              state_d = jump_halt ? ST_H : ST_F0;
              if (jump_taken) begin
                ram_en_d   = 1'b1;
                pc_en_d    = 1'b1;
                pc_rw_d    = 1'b0;
                ram_access = 1'b1;
              end
            end
            2'b10: begin
              ram_en_d   = 1'b1;
              mar_load_d = 1'b1;
              ram_access = 1'b1;
              state_d    = ST_E2;
            end
            default: begin
              do_xfer = 1'b1;
              state_d = ST_F0;
            end
          endcase
        end
      end
      ST_E2: begin
        state_d = ST_F0;
        if (is_regop) begin
          alu_en_d  = 1'b1;
          alu_op_d  = ALU_OP_W'(aluop);
          regs_en_d = dst_hot;
          regs_rw_d = ~dst_hot;
        end else if (op[3:2] == 2'b10) begin
          do_xfer = 1'b1;
        end
      end
      ST_H: begin
        if (RUN) state_d = ST_F0;
      end
      default: begin
        state_d   = ST_F0;
        illegal_d = 1'b1;
      end
    endcase

    // Register <-> RAM transfer shared by direct and indirect load/store.
    if (do_xfer) begin
      ram_en_d   = 1'b1;
      regs_en_d  = xfer_hot;
      ram_access = 1'b1;
      if (INSTR[13]) ram_rw_d  = 1'b0;
      else           regs_rw_d = ~xfer_hot;
    end

    // A stalled RAM access holds its strobes and state until ready or timeout.
    if (ram_access && !RAM_READY) begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (WAIT_MAX != 0 && wait_cnt_d == CNT_W'(WAIT_MAX)) begin
        bus_err_d = 1'b1;
        state_d   = ST_H;
      end
    end

    halted_d = (state_d == ST_H);
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_F0;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
      pc_inc_q   <= 1'b0;
      pc_rw_q    <= 1'b1;
      pc_en_q    <= 1'b0;
      mar_load_q <= 1'b0;
      mar_en_q   <= 1'b1;
      ram_rw_q   <= 1'b1;
      ram_en_q   <= 1'b0;
      ir_load_q  <= 1'b1;
      ir_en_q    <= 1'b0;
      regs_inc_q <= '0;
      regs_rw_q  <= '1;
      regs_en_q  <= '0;
      alu_en_q   <= 1'b0;
      alu_op_q   <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      pc_inc_q   <= pc_inc_d;
      pc_rw_q    <= pc_rw_d;
      pc_en_q    <= pc_en_d;
      mar_load_q <= mar_load_d;
      mar_en_q   <= mar_en_d;
      ram_rw_q   <= ram_rw_d;
      ram_en_q   <= ram_en_d;
      ir_load_q  <= ir_load_d;
      ir_en_q    <= ir_en_d;
      regs_inc_q <= regs_inc_d;
      regs_rw_q  <= regs_rw_d;
      regs_en_q  <= regs_en_d;
      alu_en_q   <= alu_en_d;
      alu_op_q   <= alu_op_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign PC_INC   = pc_inc_q;
  assign PC_RW    = pc_rw_q;
  assign PC_EN    = pc_en_q;
  assign MAR_LOAD = mar_load_q;
  assign MAR_EN   = mar_en_q;
  assign RAM_RW   = ram_rw_q;
  assign RAM_EN   = ram_en_q;
  assign IR_LOAD  = ir_load_q;
  assign IR_EN    = ir_en_q;
  assign REGS_INC = regs_inc_q;
  assign REGS_RW  = regs_rw_q;
  assign REGS_EN  = regs_en_q;
  assign ALU_EN   = alu_en_q;
  assign ALU_OP   = alu_op_q;
  assign HALTED   = halted_q;
  assign ILLEGAL  = illegal_q;
  assign BUS_ERR  = bus_err_q;

endmodule
